dcache_responder: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that serves the memory stage's D$ request port (`dc_en`, `dc_in_*`, `dc_out_*`) and fetches lines from a simple memory port. It sits between the MEM stage and the memory/bus adapter. It is the responding end of the D$ handshake. One request is outstanding at a time, and completion is signalled by a one-cycle response pulse.

---
 rtl/dcache_responder_if.sv | 36 +++
 rtl/dcache_responder.sv | 164 ++++++++++++++++
 tb/tb_dcache_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_responder_if.sv
// D$ request/response and memory port bundle for dcache_responder.
// Handshake: dc_en holds a request until a one-cycle dc_out_rvalid/dc_out_write_done pulse; mem_req holds until mem_gnt; mem_rvalid qualifies each fill beat.
interface dcache_responder_if #(
    parameter int ADDR_WIDTH = 64
);
    logic                  dc_en;
    logic [ADDR_WIDTH-1:0] dc_in_addr;
    logic                  dc_write_en;
    logic [63:0]           dc_in_wdata;
    logic [1:0]            dc_in_wlen;
    logic [63:0]           dc_out_rdata;
    logic                  dc_out_rvalid;
    logic                  dc_out_write_done;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [63:0]           mem_wdata;
    logic [7:0]            mem_wstrb;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [63:0]           mem_rdata;

    modport slave (
        input  dc_en, dc_in_addr, dc_write_en, dc_in_wdata, dc_in_wlen,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output dc_out_rdata, dc_out_rvalid, dc_out_write_done,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output dc_en, dc_in_addr, dc_write_en, dc_in_wdata, dc_in_wlen,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  dc_out_rdata, dc_out_rvalid, dc_out_write_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache answering the MEM-stage D$ port.
// One request in flight; line fills are 8 doubleword beats from a simple memory port.
module dcache_responder #(
    parameter int SETS       = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    dcache_responder_if.slave   bus,
    output logic [2:0]          o_state
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - 6 - IDX_W;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MISS_REQ = 3'd2;
    localparam logic [2:0] S_FILL     = 3'd3;
    localparam logic [2:0] S_WR_REQ   = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [63:0]           r_wdata;
    logic [1:0]            r_wlen;
    logic [2:0]            r_cnt;
    logic [63:0]           r_rdata;
    logic                  r_rvalid;
    logic                  r_wdone;
    logic [SETS-1:0]       r_valid;
    logic [TAG_W-1:0]      r_tag  [SETS];
    logic [63:0]           r_data [SETS][8];

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [2:0]            w_dw;
    logic [2:0]            w_off;
    logic                  w_hit;
    logic [63:0]           w_line_dw;
    logic [7:0]            w_len_mask;
    logic [15:0]           w_strb_wide;
    logic [7:0]            w_strb;
    logic [63:0]           w_wdata_pos;
    logic [63:0]           w_merged;

    assign w_idx       = r_addr[6 +: IDX_W];
    assign w_tag       = r_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_dw        = r_addr[5:3];
    assign w_off       = r_addr[2:0];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line_dw   = r_data[w_idx][w_dw];
    assign w_wdata_pos = r_wdata << {w_off, 3'b000};

    always_comb begin
        w_len_mask = 8'h01;
        case (r_wlen)
            2'd0:    w_len_mask = 8'h01;
            2'd1:    w_len_mask = 8'h03;
            2'd2:    w_len_mask = 8'h0F;
            default: w_len_mask = 8'hFF;
        endcase
    end

    // Bytes shifted past byte 7 by a misaligned access fall off here.
    assign w_strb_wide = {8'h00, w_len_mask} << w_off;
    assign w_strb      = w_strb_wide[7:0];

    always_comb begin
        w_merged = w_line_dw;
        for (int b = 0; b < 8; b++) begin
            if (w_strb[b]) begin
                w_merged[b*8 +: 8] = w_wdata_pos[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_valid  <= '0;
            r_rvalid <= 1'b0;
            r_wdone  <= 1'b0;
            r_rdata  <= '0;
            r_cnt    <= 3'd0;
        end else begin
            r_rvalid <= 1'b0;
            r_wdone  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.dc_en) begin
                        r_addr  <= bus.dc_in_addr;
                        r_we    <= bus.dc_write_en;
                        r_wdata <= bus.dc_in_wdata;
                        r_wlen  <= bus.dc_in_wlen;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (r_we) begin
                        r_state <= S_WR_REQ;
                    end else if (w_hit) begin
                        r_rdata  <= w_line_dw;
                        r_rvalid <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_state <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    // Invalidate up front so an aborted fill never leaves a stale tag over new data.
                    if (bus.mem_gnt) begin
                        r_cnt          <= 3'd0;
                        r_valid[w_idx] <= 1'b0;
                        r_state        <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.mem_rvalid) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_valid[w_idx] <= 1'b1;
                            r_state        <= S_LOOKUP;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (bus.mem_gnt) begin
                        r_wdone <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity alone guards them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_FILL && bus.mem_rvalid) begin
                r_data[w_idx][r_cnt] <= bus.mem_rdata;
                if (r_cnt == 3'd7) begin
                    r_tag[w_idx] <= w_tag;
                end
            end
            if (r_state == S_LOOKUP && r_we && w_hit) begin
                r_data[w_idx][w_dw] <= w_merged;
            end
        end
    end

    assign bus.dc_out_rdata      = r_rdata;
    assign bus.dc_out_rvalid     = r_rvalid;
    assign bus.dc_out_write_done = r_wdone;
    assign bus.mem_req           = (r_state == S_MISS_REQ) || (r_state == S_WR_REQ);
    assign bus.mem_we            = (r_state == S_WR_REQ);
    assign bus.mem_addr          = (r_state == S_MISS_REQ) ? {r_addr[ADDR_WIDTH-1:6], 6'b0}
                                                           : {r_addr[ADDR_WIDTH-1:3], 3'b0};
    assign bus.mem_wdata         = w_wdata_pos;
    assign bus.mem_wstrb         = (r_state == S_WR_REQ) ? w_strb : 8'h00;
    assign o_state               = r_state;
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: fills, hits, store merge, no-allocate, conflicts, held request, reset mid-fill.
module tb_dcache_responder;
    logic       clk;
    logic       reset;
    logic [2:0] o_state;

    dcache_responder_if #(.ADDR_WIDTH(64)) bus();

    dcache_responder #(.SETS(64), .ADDR_WIDTH(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .o_state (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // memory model state
    logic [63:0] mem_over [logic [63:0]];
    int          fill_count = 0;
    int          wr_count   = 0;
    int          req_cycles = 0;
    int          beats_sent = 0;
    int          beats_left = 0;
    logic [63:0] fill_base  = 64'h0;
    logic [63:0] last_raddr = 64'h0;
    logic [63:0] last_waddr = 64'h0;
    logic [63:0] last_wdata = 64'h0;
    logic [7:0]  last_wstrb = 8'h0;
    logic        fill_abort = 1'b0;
    logic        stray      = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return a ^ 64'h5A5A;
    endfunction

    // Zero-wait grant, back-to-back beats; acts on falling edges only.
    initial begin : mem_model
        logic [63:0] d;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 64'h0;
        forever begin
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (fill_abort) beats_left = 0;
            if (bus.mem_req === 1'b1) req_cycles++;
            if (stray) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
            end else if (beats_left > 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem_rd(fill_base + 64'(8 * (8 - beats_left)));
                beats_left--;
                beats_sent++;
            end else if (bus.mem_req === 1'b1) begin
                bus.mem_gnt = 1'b1;
                if (bus.mem_we) begin
                    wr_count++;
                    last_waddr = bus.mem_addr;
                    last_wdata = bus.mem_wdata;
                    last_wstrb = bus.mem_wstrb;
                    d = mem_rd(bus.mem_addr);
                    for (int b = 0; b < 8; b++)
                        if (bus.mem_wstrb[b]) d[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                    mem_over[bus.mem_addr] = d;
                end else begin
                    fill_count++;
                    last_raddr = bus.mem_addr;
                    fill_base  = bus.mem_addr;
                    beats_left = 8;
                end
            end
        end
    end

    task automatic do_load(input string tag, input logic [63:0] a, input logic [63:0] exp_data,
                           input int exp_lat, input int exp_fills);
        int lat;
        int f0;
        int r0;
        f0 = fill_count;
        r0 = req_cycles;
        @(negedge clk);
        bus.dc_en = 1'b1; bus.dc_in_addr = a; bus.dc_write_en = 1'b0;
        @(negedge clk);
        bus.dc_en = 1'b0;
        lat = 1;
        while (bus.dc_out_rvalid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_data"}, bus.dc_out_rdata, exp_data);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_fills"}, 64'(fill_count - f0), 64'(exp_fills));
        if (exp_fills > 0) check({tag, "_raddr"}, last_raddr, {a[63:6], 6'b0});
        else check({tag, "_noreq"}, 64'(req_cycles - r0), 64'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(bus.dc_out_rvalid), 64'd0);
    endtask

    task automatic do_store(input string tag, input logic [63:0] a, input logic [63:0] wd,
                            input logic [1:0] wl, input logic [63:0] exp_waddr,
                            input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
        int lat;
        int w0;
        w0 = wr_count;
        @(negedge clk);
        bus.dc_en = 1'b1; bus.dc_in_addr = a; bus.dc_write_en = 1'b1;
        bus.dc_in_wdata = wd; bus.dc_in_wlen = wl;
        @(negedge clk);
        bus.dc_en = 1'b0;
        lat = 1;
        while (bus.dc_out_write_done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd3);
        check({tag, "_writes"}, 64'(wr_count - w0), 64'd1);
        check({tag, "_waddr"}, last_waddr, exp_waddr);
        check({tag, "_wdata"}, last_wdata, exp_wdata);
        check({tag, "_wstrb"}, 64'(last_wstrb), 64'(exp_wstrb));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 64'(o_state), 64'd0);
        check({tag, "_rvalid"}, 64'(bus.dc_out_rvalid), 64'd0);
        check({tag, "_wdone"}, 64'(bus.dc_out_write_done), 64'd0);
        check({tag, "_req"}, 64'(bus.mem_req), 64'd0);
        check({tag, "_we"}, 64'(bus.mem_we), 64'd0);
        check({tag, "_rdata"}, bus.dc_out_rdata, 64'd0);
        check({tag, "_wstrb"}, 64'(bus.mem_wstrb), 64'd0);
    endtask

    initial begin : main
        int lat;
        int w0;
        int b0;
        int f0;
        int cyc;
        reset = 1'b1;
        bus.dc_en = 1'b0; bus.dc_in_addr = 64'h0; bus.dc_write_en = 1'b0;
        bus.dc_in_wdata = 64'h0; bus.dc_in_wlen = 2'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        do_load("miss_1000", 64'h1000, 64'h4A5A, 12, 1);
        do_load("hit_1008", 64'h1008, 64'h4A52, 2, 0);
        do_store("st_byte", 64'h1003, 64'hAB, 2'd0, 64'h1000, 64'hAB00_0000, 8'h08);
        do_load("hit_merged", 64'h1000, 64'hAB00_4A5A, 2, 0);

        do_store("st_miss", 64'h3000, 64'h1122_3344_5566_7788, 2'd3, 64'h3000,
                 64'h1122_3344_5566_7788, 8'hFF);
        do_load("noalloc", 64'h3000, 64'h1122_3344_5566_7788, 12, 1);

        do_load("conf_a", 64'h1000, 64'hAB00_4A5A, 12, 1);
        do_load("conf_b", 64'h2000, 64'h7A5A, 12, 1);
        do_load("conf_c", 64'h1000, 64'hAB00_4A5A, 12, 1);

        // held dc_en through completion
        w0 = wr_count;
        @(negedge clk);
        bus.dc_en = 1'b1; bus.dc_in_addr = 64'h1010; bus.dc_write_en = 1'b1;
        bus.dc_in_wdata = 64'hCAFE_F00D; bus.dc_in_wlen = 2'd2;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.dc_out_write_done !== 1'b1 && lat < 200);
        check("held_lat", 64'(lat), 64'd3);
        check("held_writes1", 64'(wr_count - w0), 64'd1);
        check("held_wstrb", 64'(last_wstrb), 64'h0F);
        check("held_wdata", last_wdata, 64'hCAFE_F00D);
        @(negedge clk);
        check("held_wdone_low", 64'(bus.dc_out_write_done), 64'd0);
        check("held_idle", 64'(o_state), 64'd0);
        @(negedge clk);
        check("held_reaccept", 64'(o_state), 64'd1);
        check("held_one_write", 64'(wr_count - w0), 64'd1);
        bus.dc_en = 1'b0;
        lat = 0;
        while (bus.dc_out_write_done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("held_writes2", 64'(wr_count - w0), 64'd2);
        @(negedge clk);

        // reset after three fill beats
        b0 = beats_sent;
        @(negedge clk);
        bus.dc_en = 1'b1; bus.dc_in_addr = 64'h2040; bus.dc_write_en = 1'b0;
        @(negedge clk);
        bus.dc_en = 1'b0;
        cyc = 0;
        while (beats_sent - b0 < 3 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        fill_abort = 1'b1;
        check("rst_beats", 64'(beats_sent - b0), 64'd3);
        check("rst_in_fill", 64'(o_state), 64'd3);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("midfill_rst");
        reset = 1'b0;
        @(posedge clk);
        #1;
        fill_abort = 1'b0;
        stray = 1'b1;
        @(posedge clk);
        #1;
        stray = 1'b0;
        @(negedge clk);
        check("stray_state", 64'(o_state), 64'd0);
        check("stray_req", 64'(bus.mem_req), 64'd0);
        check("stray_rvalid", 64'(bus.dc_out_rvalid), 64'd0);
        b0 = beats_sent;
        f0 = fill_count;
        do_load("refill", 64'h2040, 64'h7A1A, 12, 1);
        check("refill_beats", 64'(beats_sent - b0), 64'd8);
        check("refill_count", 64'(fill_count - f0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
